interrupt_ack_sequencer: RTL and testbench

INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

---
 rtl/pic_pkg.sv | 25 ++
 rtl/inta_edge_sync.sv | 35 +++
 rtl/interrupt_ack_sequencer.sv | 160 ++++++++++++++++
 tb/tb_interrupt_ack_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the interrupt acknowledge sequencer.
package pic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2,
        ST_ACK3 = 2'd3
    } state_e;

    localparam logic [7:0] CALL_OPCODE    = 8'hCD;
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    function automatic logic [7:0] level_onehot(input logic [2:0] lvl);
        return 8'b1 << lvl;
    endfunction

    // Bits 0..lvl set: every level at or above lvl in priority.
    function automatic logic [7:0] upto_mask(input logic [2:0] lvl);
        logic [7:0] oh;
        oh = level_onehot(lvl);
        return (oh << 1) - 8'd1;
    endfunction

endpackage

// File: rtl/inta_edge_sync.sv
// Two-flop synchroniser for INTA# with fall/rise event pulses.
module inta_edge_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic inta_n,
    output logic fall,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic dly_q, dly_d;

    always_comb begin
        sync1_d = inta_n;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
        end
    end

    assign fall = dly_q & ~sync2_q;
    assign rise = ~dly_q & sync2_q;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259-style INTA sequencer: ISR set/clear and vector bytes for 8080/8086 modes.
import pic_pkg::*;

module interrupt_ack_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       inta_n,
    input  logic       mode_8086,
    input  logic       auto_eoi,
    input  logic       interval4,
    input  logic [2:0] icw1_addr,
    input  logic [7:0] icw2,
    input  logic       chosen_valid,
    input  logic [2:0] chosen_level,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] isr,
    output logic [7:0] clr_irr,
    output logic [7:0] vector_data,
    output logic       vector_oe
);

    logic inta_fall, inta_rise;

    inta_edge_sync u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .inta_n  (inta_n),
        .fall    (inta_fall),
        .rise    (inta_rise)
    );

    state_e     state_q, state_d;
    logic [2:0] level_q, level_d;
    logic       spur_q, spur_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] clr_q, clr_d;
    logic [7:0] data_q, data_d;
    logic       oe_q, oe_d;
    logic       int_q, int_d;
    logic       set_en, final_rise;
    logic [7:0] eoi_clr;

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        spur_d     = spur_q;
        oe_d       = oe_q;
        set_en     = 1'b0;
        final_rise = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (inta_fall) begin
                    level_d = chosen_valid ? chosen_level : SPURIOUS_LEVEL;
                    spur_d  = ~chosen_valid;
                    set_en  = chosen_valid;
                    state_d = ST_ACK1;
                    oe_d    = ~mode_8086;
                end
            end
            ST_ACK1: begin
                if (inta_fall) begin
                    state_d = ST_ACK2;
                    oe_d    = 1'b1;
                end else if (inta_rise) begin
                    oe_d = 1'b0;
                end
            end
            ST_ACK2: begin
                if (inta_rise) begin
                    oe_d = 1'b0;
                    if (mode_8086) begin
                        state_d    = ST_IDLE;
                        final_rise = 1'b1;
                    end
                end else if (inta_fall && !mode_8086) begin
                    state_d = ST_ACK3;
                    oe_d    = 1'b1;
                end
            end
            ST_ACK3: begin
                if (inta_rise) begin
                    oe_d       = 1'b0;
                    state_d    = ST_IDLE;
                    final_rise = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // EOI clears go in first so a same-cycle INTA set wins on a shared bit.
    always_comb begin
        eoi_clr = 8'h00;
        if (eoi_valid) begin
            eoi_clr = eoi_specific ? level_onehot(eoi_level)
                                   : isr_q & (~isr_q + 8'd1);
        end
        isr_d = isr_q & ~eoi_clr;
        if (final_rise && auto_eoi && !spur_q) begin
            isr_d = isr_d & ~level_onehot(level_q);
        end
        if (set_en) begin
            isr_d = isr_d | level_onehot(level_d);
        end
        clr_d = set_en ? level_onehot(level_d) : 8'h00;
        int_d = (state_d == ST_IDLE) && chosen_valid &&
                ~|(isr_d & upto_mask(chosen_level));
    end

    always_comb begin
        data_d = 8'h00;
        if (oe_d) begin
            unique case (state_d)
                ST_ACK1: data_d = CALL_OPCODE;
                ST_ACK2: begin
                    if (mode_8086)
                        data_d = {icw2[7:3], level_d};
                    else if (interval4)
                        data_d = {icw1_addr, level_d, 2'b00};
                    else
                        data_d = {icw1_addr[2:1], level_d, 3'b000};
                end
                ST_ACK3: data_d = icw2;
                default: data_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            level_q <= 3'd0;
            spur_q  <= 1'b0;
            isr_q   <= 8'h00;
            clr_q   <= 8'h00;
            data_q  <= 8'h00;
            oe_q    <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            spur_q  <= spur_d;
            isr_q   <= isr_d;
            clr_q   <= clr_d;
            data_q  <= data_d;
            oe_q    <= oe_d;
            int_q   <= int_d;
        end
    end

    assign int_out     = int_q;
    assign isr         = isr_q;
    assign clr_irr     = clr_q;
    assign vector_data = data_q;
    assign vector_oe   = oe_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer with immediate assertions.
import pic_pkg::*;

module tb_interrupt_ack_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       inta_n = 1'b1;
    logic       mode_8086 = 1'b1;
    logic       auto_eoi = 1'b0;
    logic       interval4 = 1'b0;
    logic [2:0] icw1_addr = 3'd0;
    logic [7:0] icw2 = 8'h00;
    logic       chosen_valid = 1'b0;
    logic [2:0] chosen_level = 3'd0;
    logic       eoi_valid = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       int_out;
    logic [7:0] isr;
    logic [7:0] clr_irr;
    logic [7:0] vector_data;
    logic       vector_oe;

    int n_assert = 0;
    int n_fail = 0;

    interrupt_ack_sequencer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .inta_n       (inta_n),
        .mode_8086    (mode_8086),
        .auto_eoi     (auto_eoi),
        .interval4    (interval4),
        .icw1_addr    (icw1_addr),
        .icw2         (icw2),
        .chosen_valid (chosen_valid),
        .chosen_level (chosen_level),
        .eoi_valid    (eoi_valid),
        .eoi_specific (eoi_specific),
        .eoi_level    (eoi_level),
        .int_out      (int_out),
        .isr          (isr),
        .clr_irr      (clr_irr),
        .vector_data  (vector_data),
        .vector_oe    (vector_oe)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fall_phase(input string tag, input logic [7:0] e_clr,
                              input logic e_oe, input logic [7:0] e_data);
        inta_n = 1'b0;
        repeat (3) tick();
        chk({tag, " clr"}, clr_irr, e_clr);
        tick();
        chk({tag, " clr_end"}, clr_irr, 8'h00);
        tick();
        chk({tag, " oe"}, {7'd0, vector_oe}, {7'd0, e_oe});
        chk({tag, " data"}, vector_data, e_data);
        chk({tag, " int"}, {7'd0, int_out}, 8'h00);
    endtask

    task automatic rise_phase(input string tag);
        inta_n = 1'b1;
        repeat (5) tick();
        chk({tag, " oe_off"}, {7'd0, vector_oe}, 8'h00);
        chk({tag, " data_off"}, vector_data, 8'h00);
    endtask

    task automatic eoi(input logic spec, input logic [2:0] lvl,
                       input logic [7:0] e_isr, input string tag);
        eoi_specific = spec;
        eoi_level = lvl;
        eoi_valid = 1'b1;
        tick();
        eoi_valid = 1'b0;
        chk(tag, isr, e_isr);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst isr", isr, 8'h00);
        chk("rst oe", {7'd0, vector_oe}, 8'h00);
        chk("rst data", vector_data, 8'h00);
        chk("rst int", {7'd0, int_out}, 8'h00);
        chk("rst clr", clr_irr, 8'h00);

        // 8086 two-pulse, level 3
        mode_8086 = 1'b1;
        icw2 = 8'h40;
        chosen_valid = 1'b1;
        chosen_level = 3'd3;
        reset_n = 1'b1;
        repeat (2) tick();
        chk("int idle", {7'd0, int_out}, 8'h01);
        fall_phase("86a p1", 8'h08, 1'b0, 8'h00);
        chk("86a isr", isr, 8'h08);
        rise_phase("86a r1");
        chk("86a int ack1", {7'd0, int_out}, 8'h00);
        fall_phase("86a p2", 8'h00, 1'b1, 8'h43);
        rise_phase("86a r2");
        chk("86a int blocked", {7'd0, int_out}, 8'h00);
        chosen_level = 3'd5;
        tick();
        chk("int masked lvl5", {7'd0, int_out}, 8'h00);

        // second ack at level 5 builds isr=28 for the EOI checks
        fall_phase("86b p1", 8'h20, 1'b0, 8'h00);
        rise_phase("86b r1");
        fall_phase("86b p2", 8'h00, 1'b1, 8'h45);
        rise_phase("86b r2");
        chk("isr 28", isr, 8'h28);
        eoi(1'b0, 3'd0, 8'h20, "eoi nonspec");
        eoi(1'b1, 3'd5, 8'h00, "eoi spec5");
        eoi(1'b0, 3'd0, 8'h00, "eoi empty");
        tick();
        chk("int after eoi", {7'd0, int_out}, 8'h01);

        // 8080 three-pulse, interval 8
        mode_8086 = 1'b0;
        interval4 = 1'b0;
        icw1_addr = 3'b101;
        icw2 = 8'h12;
        chosen_level = 3'd2;
        tick();
        fall_phase("80a p1", 8'h04, 1'b1, 8'hCD);
        rise_phase("80a r1");
        fall_phase("80a p2", 8'h00, 1'b1, 8'h90);
        rise_phase("80a r2");
        fall_phase("80a p3", 8'h00, 1'b1, 8'h12);
        rise_phase("80a r3");
        chk("80a isr", isr, 8'h04);
        eoi(1'b1, 3'd2, 8'h00, "eoi spec2");

        // 8080 interval 4, level change mid-sequence is ignored
        interval4 = 1'b1;
        fall_phase("80b p1", 8'h04, 1'b1, 8'hCD);
        chosen_level = 3'd6;
        rise_phase("80b r1");
        fall_phase("80b p2", 8'h00, 1'b1, 8'hA8);
        rise_phase("80b r2");
        fall_phase("80b p3", 8'h00, 1'b1, 8'h12);
        rise_phase("80b r3");
        chk("80b isr", isr, 8'h04);
        eoi(1'b0, 3'd0, 8'h00, "eoi nonspec2");

        // spurious
        mode_8086 = 1'b1;
        icw2 = 8'h08;
        chosen_valid = 1'b0;
        tick();
        chk("spur int", {7'd0, int_out}, 8'h00);
        fall_phase("sp p1", 8'h00, 1'b0, 8'h00);
        chk("sp isr1", isr, 8'h00);
        rise_phase("sp r1");
        fall_phase("sp p2", 8'h00, 1'b1, 8'h0F);
        rise_phase("sp r2");
        chk("sp isr2", isr, 8'h00);

        // auto-EOI at level 6
        auto_eoi = 1'b1;
        chosen_valid = 1'b1;
        chosen_level = 3'd6;
        fall_phase("ae p1", 8'h40, 1'b0, 8'h00);
        chk("ae isr1", isr, 8'h40);
        rise_phase("ae r1");
        fall_phase("ae p2", 8'h00, 1'b1, 8'h0E);
        chk("ae isr2", isr, 8'h40);
        rise_phase("ae r2");
        chk("ae isr3", isr, 8'h00);
        auto_eoi = 1'b0;
        chosen_level = 3'd1;
        fall_phase("l1 p1", 8'h02, 1'b0, 8'h00);
        rise_phase("l1 r1");
        fall_phase("l1 p2", 8'h00, 1'b1, 8'h09);
        rise_phase("l1 r2");
        chk("isr 02", isr, 8'h02);
        chosen_level = 3'd4;
        repeat (2) tick();
        chk("int blocked by 1", {7'd0, int_out}, 8'h00);

        // reset in ACK2 while driving the bus
        chosen_level = 3'd0;
        fall_phase("rs p1", 8'h01, 1'b0, 8'h00);
        rise_phase("rs r1");
        inta_n = 1'b0;
        repeat (5) tick();
        chk("rs oe on", {7'd0, vector_oe}, 8'h01);
        chk("rs data on", vector_data, 8'h08);
        reset_n = 1'b0;
        #1;
        chk("rs oe async", {7'd0, vector_oe}, 8'h00);
        chk("rs isr async", isr, 8'h00);
        chk("rs data async", vector_data, 8'h00);
        inta_n = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("rs state", 8'(dut.state_q), 8'(ST_IDLE));
        chk("rs oe idle", {7'd0, vector_oe}, 8'h00);
        icw2 = 8'h40;
        chosen_level = 3'd3;
        tick();
        chk("rs int", {7'd0, int_out}, 8'h01);
        fall_phase("rs2 p1", 8'h08, 1'b0, 8'h00);
        rise_phase("rs2 r1");
        fall_phase("rs2 p2", 8'h00, 1'b1, 8'h43);
        rise_phase("rs2 r2");
        chk("rs2 isr", isr, 8'h08);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
